// File: rtl/bluejay_pkg.sv
// Shared types and default sizing for the bluejay frame sequencer.
package bluejay_pkg;

  localparam int DEF_WORDS_PER_LINE  = 40;
  localparam int DEF_LINES_PER_FRAME = 1280;
  localparam int DEF_FIFO_DEPTH      = 512;
  localparam int DEF_SWITCH_TIMEOUT  = 65535;

  localparam int LINE_W  = 11;
  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LINE   = 3'd1,
    SEND_LINE   = 3'd2,
    SWITCH_REQ  = 3'd3,
    SWITCH_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/bluejay_fill_counter.sv
// Up/down occupancy counter for a FIFO; saturates at 0 and DEPTH and
// raises sticky overflow/underflow flags instead of wrapping.
module bluejay_fill_counter #(
  parameter int  DEPTH = 512,
  localparam int W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] fill,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push && !pop) begin
      if (fill == FULL) overflow <= 1'b1;
      else              fill     <= fill + W'(1);
    end else if (pop && !push) begin
      if (fill == '0) underflow <= 1'b1;
      else            fill      <= fill - W'(1);
    end
  end

endmodule

// File: rtl/bluejay_frame_ctrl.sv
// Frame sequencer: paces bluejay_data against the sc32 line FIFO, counts
// words/lines per frame and runs the display buffer-swap handshake.
module bluejay_frame_ctrl
  import bluejay_pkg::*;
#(
  parameter int  WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int  LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int  FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int  SWITCH_TIMEOUT  = DEF_SWITCH_TIMEOUT,
  localparam int FILL_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               fpga_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               fifo_push,
  input  logic               get_next_word,
  input  logic               valid,
  output logic               line_of_data_available,
  output logic               buffer_switch_done,
  output logic               update_req,
  input  logic               update_ack,
  output logic [LINE_W-1:0]  line_count,
  output logic [FRAME_W-1:0] frame_count,
  output logic               busy,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_timeout,
  output state_t             fsm_state,
  output logic [FILL_W-1:0]  fill_level
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE + 1);
  localparam int TMR_W  = $clog2(SWITCH_TIMEOUT + 1);

  state_t             state, state_next;
  logic [WORD_W-1:0]  word_cnt, word_next;
  logic [LINE_W-1:0]  line_next;
  logic [FRAME_W-1:0] frame_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic               timeout_set;
  logic               lda_next;

  bluejay_fill_counter #(.DEPTH(FIFO_DEPTH)) u_fill (
    .clk       (fpga_clk),
    .rst_n     (reset_n),
    .push      (fifo_push),
    .pop       (get_next_word),
    .fill      (fill_level),
    .overflow  (err_overflow),
    .underflow (err_underflow)
  );

  // Swap handshake: update_req is held high for the whole SWITCH_REQ stay;
  // the first cycle update_ack is sampled high completes the swap. There is
  // no back-pressure on it, and a missing ack is bounded by SWITCH_TIMEOUT.
  assign update_req         = (state == SWITCH_REQ);
  assign buffer_switch_done = (state == SWITCH_DONE);
  assign busy               = (state != IDLE);
  assign fsm_state          = state;

  always_comb begin
    state_next  = state;
    word_next   = word_cnt;
    line_next   = line_count;
    frame_next  = frame_count;
    timer_next  = '0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (valid) begin
          state_next = SEND_LINE;
          word_next  = WORD_W'(1);
        end
      end
      SEND_LINE: begin
        if (valid) begin
          if (word_cnt == WORD_W'(WORDS_PER_LINE - 1)) begin
            word_next = '0;
            if (line_count == LINE_W'(LINES_PER_FRAME - 1)) begin
              line_next  = '0;
              state_next = SWITCH_REQ;
            end else begin
              line_next  = line_count + LINE_W'(1);
              state_next = WAIT_LINE;
            end
          end else begin
            word_next = word_cnt + WORD_W'(1);
          end
        end
      end
      SWITCH_REQ: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (update_ack) begin
          state_next = SWITCH_DONE;
          frame_next = frame_count + FRAME_W'(1);
        end else if (timer == TMR_W'(SWITCH_TIMEOUT - 1)) begin
          state_next  = IDLE;
          timeout_set = 1'b1;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      SWITCH_DONE: begin
        state_next = enable ? WAIT_LINE : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Only advertised while parked in WAIT_LINE; drops on the edge leaving it.
    lda_next = (state == WAIT_LINE) && (state_next == WAIT_LINE) &&
               (fill_level >= FILL_W'(WORDS_PER_LINE));
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      word_cnt               <= '0;
      line_count             <= '0;
      frame_count            <= '0;
      timer                  <= '0;
      line_of_data_available <= 1'b0;
      err_timeout            <= 1'b0;
    end else begin
      state                  <= state_next;
      word_cnt               <= word_next;
      line_count             <= line_next;
      frame_count            <= frame_next;
      timer                  <= timer_next;
      line_of_data_available <= lda_next;
      if (timeout_set) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bluejay_frame_ctrl.sv
// Directed bench for bluejay_frame_ctrl: a cycle table for the main frame
// flow plus hand-written sequences for timeout, saturation, enable and reset.
module tb_bluejay_frame_ctrl;
  import bluejay_pkg::*;

  localparam int WPL   = 4;
  localparam int LPF   = 2;
  localparam int DEPTH = 16;
  localparam int TO    = 8;
  localparam int NVEC  = 21;

  logic        fpga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_push = 1'b0;
  logic        get_next_word = 1'b0;
  logic        valid = 1'b0;
  logic        update_ack = 1'b0;
  logic        line_of_data_available, buffer_switch_done, update_req, busy;
  logic [10:0] line_count;
  logic [15:0] frame_count;
  logic        err_overflow, err_underflow, err_timeout;
  state_t      fsm_state;
  logic [4:0]  fill_level;

  bluejay_frame_ctrl #(
    .WORDS_PER_LINE  (WPL),
    .LINES_PER_FRAME (LPF),
    .FIFO_DEPTH      (DEPTH),
    .SWITCH_TIMEOUT  (TO)
  ) dut (
    .fpga_clk               (fpga_clk),
    .reset_n                (reset_n),
    .enable                 (enable),
    .fifo_push              (fifo_push),
    .get_next_word          (get_next_word),
    .valid                  (valid),
    .line_of_data_available (line_of_data_available),
    .buffer_switch_done     (buffer_switch_done),
    .update_req             (update_req),
    .update_ack             (update_ack),
    .line_count             (line_count),
    .frame_count            (frame_count),
    .busy                   (busy),
    .err_overflow           (err_overflow),
    .err_underflow          (err_underflow),
    .err_timeout            (err_timeout),
    .fsm_state              (fsm_state),
    .fill_level             (fill_level)
  );

  // ---------------- clock / watchdog ----------------
  always #5 fpga_clk = ~fpga_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- table record ----------------
  // stim = {enable, push, pop, valid, ack}; obs = {lda, busy, update_req, switch_done}
  typedef struct packed {
    logic [4:0]  stim;
    logic [3:0]  obs;
    logic [10:0] line;
    logic [15:0] frame;
    logic [4:0]  fill;
  } vec_t;

  vec_t        vecs[NVEC];
  logic [38:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input logic [4:0] stim, input logic [3:0] obs,
                              input logic [10:0] line, input logic [15:0] frame,
                              input logic [4:0] fill);
    vec_t v;
    v.stim  = stim;
    v.obs   = obs;
    v.line  = line;
    v.frame = frame;
    v.fill  = fill;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // code = {push, pop, valid, ack}; inputs change at negedge, outputs read at the next negedge
  task automatic step(input logic [3:0] code);
    {fifo_push, get_next_word, valid, update_ack} = code;
    @(posedge fpga_clk);
    @(negedge fpga_clk);
    {fifo_push, get_next_word, valid, update_ack} = 4'b0000;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) step(4'b1000);
  endtask

  task automatic send_line();
    for (int i = 0; i < WPL; i++) step(4'b0110);
  endtask

  task automatic wait_lda(input string name);
    for (int i = 0; i < 20 && !line_of_data_available; i++) step(4'b0000);
    check(name, 64'(line_of_data_available), 64'd1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge fpga_clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({line_of_data_available, buffer_switch_done, update_req, busy,
                line_count, frame_count, err_overflow, err_underflow, err_timeout,
                fill_level, fsm_state});
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int   n;
    logic seen_lda;
    logic [38:0] exp;

    // Push 8, two 4-word lines, ack two cycles after update_req rises.
    vecs[0]  = mk(5'b11000, 4'b0100, 11'd0, 16'd0, 5'd1);
    vecs[1]  = mk(5'b11000, 4'b0100, 11'd0, 16'd0, 5'd2);
    vecs[2]  = mk(5'b11000, 4'b0100, 11'd0, 16'd0, 5'd3);
    vecs[3]  = mk(5'b11000, 4'b0100, 11'd0, 16'd0, 5'd4);
    vecs[4]  = mk(5'b11000, 4'b1100, 11'd0, 16'd0, 5'd5);
    vecs[5]  = mk(5'b11000, 4'b1100, 11'd0, 16'd0, 5'd6);
    vecs[6]  = mk(5'b11000, 4'b1100, 11'd0, 16'd0, 5'd7);
    vecs[7]  = mk(5'b11000, 4'b1100, 11'd0, 16'd0, 5'd8);
    vecs[8]  = mk(5'b10110, 4'b0100, 11'd0, 16'd0, 5'd7);
    vecs[9]  = mk(5'b10110, 4'b0100, 11'd0, 16'd0, 5'd6);
    vecs[10] = mk(5'b10110, 4'b0100, 11'd0, 16'd0, 5'd5);
    vecs[11] = mk(5'b10110, 4'b0100, 11'd1, 16'd0, 5'd4);
    vecs[12] = mk(5'b10000, 4'b1100, 11'd1, 16'd0, 5'd4);
    vecs[13] = mk(5'b10110, 4'b0100, 11'd1, 16'd0, 5'd3);
    vecs[14] = mk(5'b10110, 4'b0100, 11'd1, 16'd0, 5'd2);
    vecs[15] = mk(5'b10110, 4'b0100, 11'd1, 16'd0, 5'd1);
    vecs[16] = mk(5'b10110, 4'b0110, 11'd0, 16'd0, 5'd0);
    vecs[17] = mk(5'b10000, 4'b0110, 11'd0, 16'd0, 5'd0);
    vecs[18] = mk(5'b10000, 4'b0110, 11'd0, 16'd0, 5'd0);
    vecs[19] = mk(5'b10001, 4'b0101, 11'd0, 16'd1, 5'd0);
    vecs[20] = mk(5'b10000, 4'b0100, 11'd0, 16'd1, 5'd0);

    // Reset state
    repeat (3) @(negedge fpga_clk);
    check("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;

    // Table: expected {obs, line, frame, fill, errors=000} go through exp_q
    for (int i = 0; i < NVEC; i++) exp_q.push_back({vecs[i].obs, vecs[i].line, vecs[i].frame, vecs[i].fill, 3'b000});
    for (int i = 0; i < NVEC; i++) begin
      enable = vecs[i].stim[4];
      step(vecs[i].stim[3:0]);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d", i),
            64'({line_of_data_available, busy, update_req, buffer_switch_done,
                 line_count, frame_count, fill_level,
                 err_overflow, err_underflow, err_timeout}),
            64'(exp));
    end

    // Second frame with update_ack withheld: timeout after TO cycles
    push_n(8);
    wait_lda("to_lda0");
    send_line();
    wait_lda("to_lda1");
    enable = 1'b0;
    send_line();
    check("to_req_rise", 64'(update_req), 64'd1);
    n = 0;
    while (update_req && n < 20) begin
      step(4'b0000);
      n++;
    end
    check("to_cycles", 64'(n), 64'(TO));
    check("to_err", 64'(err_timeout), 64'd1);
    check("to_state", 64'(fsm_state), 64'(IDLE));
    check("to_req_low", 64'(update_req), 64'd0);
    check("to_frame_hold", 64'(frame_count), 64'd1);
    check("to_no_done", 64'(buffer_switch_done), 64'd0);
    step(4'b0000);
    check("to_idle_stays", 64'(busy), 64'd0);

    // Fill saturation at DEPTH and at zero
    push_n(DEPTH);
    check("fill_full", 64'(fill_level), 64'(DEPTH));
    step(4'b1100);
    check("pushpop_full_fill", 64'(fill_level), 64'(DEPTH));
    check("pushpop_full_ovf", 64'(err_overflow), 64'd0);
    step(4'b1000);
    check("ovf_fill", 64'(fill_level), 64'(DEPTH));
    check("ovf_flag", 64'(err_overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) step(4'b0100);
    check("empty_fill", 64'(fill_level), 64'd0);
    check("empty_no_udf", 64'(err_underflow), 64'd0);
    step(4'b0100);
    check("udf_fill", 64'(fill_level), 64'd0);
    check("udf_flag", 64'(err_underflow), 64'd1);
    check("ovf_sticky", 64'(err_overflow), 64'd1);

    // Enable dropped during line 0: frame still completes with a swap
    apply_reset();
    check("rst_clears_err", 64'({err_overflow, err_underflow, err_timeout}), 64'd0);
    enable = 1'b1;
    push_n(8);
    wait_lda("en_lda0");
    step(4'b0110);
    enable = 1'b0;
    for (int i = 0; i < WPL - 1; i++) step(4'b0110);
    check("en_line1", 64'(line_count), 64'd1);
    wait_lda("en_lda1");
    send_line();
    check("en_req", 64'(update_req), 64'd1);
    step(4'b0000);
    step(4'b0001);
    check("en_done_pulse", 64'(buffer_switch_done), 64'd1);
    check("en_frame", 64'(frame_count), 64'd1);
    step(4'b0000);
    check("en_done_once", 64'(buffer_switch_done), 64'd0);
    check("en_busy_low", 64'(busy), 64'd0);
    check("en_state_idle", 64'(fsm_state), 64'(IDLE));
    seen_lda = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(i < 4 ? 4'b1000 : 4'b0000);
      seen_lda |= line_of_data_available;
    end
    check("en_no_lda", 64'(seen_lda), 64'd0);

    // Reset in SEND_LINE at word 2, then a clean line from word 0
    enable = 1'b1;
    wait_lda("rs_lda");
    step(4'b0110);
    step(4'b0110);
    check("rs_in_send", 64'(fsm_state), 64'(SEND_LINE));
    reset_n = 1'b0;
    #1;
    check("rs_async_outputs", all_outs(), 64'd0);
    @(negedge fpga_clk);
    reset_n = 1'b1;
    push_n(WPL);
    wait_lda("rs_lda2");
    for (int i = 0; i < WPL - 1; i++) step(4'b0110);
    check("rs_mid_line", 64'(line_count), 64'd0);
    step(4'b0110);
    check("rs_line_done", 64'(line_count), 64'd1);
    check("rs_back_wait", 64'(fsm_state), 64'(WAIT_LINE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
